// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI configuration target.
package spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] ADDR_MAX       = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-bit flop-chain synchronizer with a per-bit reset value.
module sync_ff #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target holding the five PWM configuration registers.
// Frame: bit 15 = write flag, bits 14:8 = address, bits 7:0 = data.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic [2:0] sync_q;
  logic       sclk_s, copi_s, ncs_s;
  logic       sclk_d, ncs_d;
  logic       ncs_fall, ncs_rise, sclk_rise;

  sync_ff #(
    .WIDTH    (3),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(3'b100)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({ncs, copi, sclk}),
    .q    (sync_q)
  );

  assign {ncs_s, copi_s, sclk_s} = sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_d  <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ncs_d  <= ncs_s;
      sclk_d <= sclk_s;
    end
  end

  assign ncs_fall  = ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  spi_state_e state, state_next;
  logic       clear, shift_en, commit_en;
  logic [4:0] bit_cnt;
  logic [15:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    shift_en   = 1'b0;
    commit_en  = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          state_next = SHIFT;
          clear      = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise)       state_next = COMMIT;
        else if (sclk_rise) shift_en   = 1'b1;
      end
      COMMIT: begin
        state_next = IDLE;
        commit_en  = (bit_cnt == CNT_FULL) && shreg[15] && (shreg[14:8] <= ADDR_MAX);
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter saturates one past a full frame so over-long frames stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[14:0], copi_s};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (commit_en) begin
      case (shreg[14:8])
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
        ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
        default: ;
      endcase
    end
  end

endmodule
